// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one-cycle release turnaround and an optional grant watchdog.
// Define BUS_ARBITER_WATCHDOG_EN to build in the watchdog counter; otherwise watchdog is tied low.
`timescale 1ns/1ps
module bus_arbiter #(
    parameter int N_MASTERS       = 4,
    parameter int WATCHDOG_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] bus_req,
    output logic [N_MASTERS-1:0] bus_grant,
    input  logic                 fc_bus,
    output logic                 watchdog,
    output logic [2:0]           owner,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(WATCHDOG_CYCLES - 1);

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           req_ext;
    logic [3:0]           cand;
    logic [2:0]           winner;
    logic                 win_vld;
    logic [N_MASTERS-1:0] win_onehot;
    logic                 grant_start;
    logic                 owner_drop;

    assign req_ext     = 8'(bus_req);
    assign win_onehot  = {{(N_MASTERS-1){1'b0}}, 1'b1} << winner;
    assign grant_start = (state == IDLE) && win_vld;
    assign owner_drop  = (state == GRANTED) && !req_ext[owner];
    assign busy        = |bus_grant;

    // Scan from owner+N down to owner+1 so the nearest requester after owner wins;
    // owner itself (offset N) is only taken when it is the sole requester.
    always_comb begin
        winner  = owner;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            cand = {1'b0, owner} + 4'(i);
            if (cand >= 4'(N_MASTERS)) begin
                cand = cand - 4'(N_MASTERS);
            end
            if (req_ext[cand[2:0]]) begin
                winner  = cand[2:0];
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = GRANTED;
            GRANTED: if (!req_ext[owner]) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bus_grant <= '0;
            owner     <= 3'(N_MASTERS - 1);
        end else begin
            state <= state_nxt;
            if (grant_start) begin
                bus_grant <= win_onehot;
                owner     <= winner;
            end else if (owner_drop) begin
                bus_grant <= '0;
            end
        end
    end

`ifdef BUS_ARBITER_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        wd_done;

    // The counter stops for the rest of the tenure once fc_bus is seen or the pulse has fired.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt   <= '0;
            wd_done  <= 1'b0;
            watchdog <= 1'b0;
        end else begin
            watchdog <= 1'b0;
            if (grant_start) begin
                wd_cnt  <= '0;
                wd_done <= 1'b0;
            end else if (state == GRANTED && !wd_done) begin
                if (fc_bus) begin
                    wd_done <= 1'b1;
                end else if (wd_cnt == WD_LAST) begin
                    wd_done  <= 1'b1;
                    watchdog <= req_ext[owner];
                end else begin
                    wd_cnt <= wd_cnt + 16'd1;
                end
            end
        end
    end
`else
    logic unused_wd;
    assign unused_wd = ^{fc_bus, WD_LAST};
    assign watchdog  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, round-robin order, release spacing, watchdog and async reset.
`timescale 1ns/1ps
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int WD = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bus_req;
    logic [3:0] bus_grant;
    logic       fc_bus;
    logic       watchdog;
    logic [2:0] owner;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.N_MASTERS(N), .WATCHDOG_CYCLES(WD)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_req   (bus_req),
        .bus_grant (bus_grant),
        .fc_bus    (fc_bus),
        .watchdog  (watchdog),
        .owner     (owner),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Owner's request is already absent from req: release edge, idle edge, then new grant.
    task automatic handover(input logic [3:0] req, input int idx, input string tag);
        bus_req = req;
        tick();
        chk({tag, "_release_grant"}, 32'(bus_grant), 32'h0);
        chk({tag, "_release_busy"}, 32'(busy), 32'h0);
        tick();
        chk({tag, "_idle_grant"}, 32'(bus_grant), 32'h0);
        tick();
        chk({tag, "_grant"}, 32'(bus_grant), 32'h1 << idx);
        chk({tag, "_owner"}, 32'(owner), 32'(idx));
        chk({tag, "_busy"}, 32'(busy), 32'h1);
    endtask

    // Hold the tenure for ncyc edges; fc_bus is sampled high only at edge fc_at,
    // watchdog is expected high only after edge wd_at (0 = never).
    task automatic hold_check(input int ncyc, input int wd_at, input int fc_at,
                              input logic [3:0] gnt, input string tag);
        for (int k = 1; k <= ncyc; k++) begin
            fc_bus = (k == fc_at);
            tick();
            chk({tag, "_watchdog"}, 32'(watchdog), 32'(k == wd_at));
        end
        fc_bus = 1'b0;
        chk({tag, "_grant_held"}, 32'(bus_grant), 32'(gnt));
    endtask

    initial begin
        rst     = 1'b0;
        bus_req = 4'b0000;
        fc_bus  = 1'b0;
        tick();
        tick();
        chk("reset_grant", 32'(bus_grant), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_watchdog", 32'(watchdog), 32'h0);
        chk("reset_owner", 32'(owner), 32'd3);

        rst     = 1'b1;
        bus_req = 4'b0001;
        tick();
        chk("first_grant", 32'(bus_grant), 32'h1);
        chk("first_owner", 32'(owner), 32'd0);
        chk("first_busy", 32'(busy), 32'h1);

        // All masters request; each owner drops 3 edges into its tenure and re-raises.
        bus_req = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_stable1", 32'(bus_grant), 32'h1 << k);
            tick();
            chk("rr_stable2", 32'(bus_grant), 32'h1 << k);
            bus_req    = 4'hF;
            bus_req[k] = 1'b0;
            tick();
            chk("rr_release", 32'(bus_grant), 32'h0);
            bus_req = 4'hF;
            tick();
            chk("rr_idle", 32'(bus_grant), 32'h0);
            tick();
            chk("rr_next_grant", 32'(bus_grant), 32'h1 << ((k + 1) % 4));
            chk("rr_next_owner", 32'(owner), 32'((k + 1) % 4));
        end

        // Sole requester equal to owner is granted again.
        bus_req = 4'b0000;
        tick();
        chk("solo_release", 32'(bus_grant), 32'h0);
        tick();
        tick();
        chk("solo_idle", 32'(bus_grant), 32'h0);
        bus_req = 4'b0001;
        tick();
        chk("solo_regrant", 32'(bus_grant), 32'h1);
        chk("solo_owner", 32'(owner), 32'd0);

`ifdef BUS_ARBITER_WATCHDOG_EN
        handover(4'b0010, 1, "wd_m1");
        hold_check(300, WD, 0, 4'b0010, "wd_timeout");
        handover(4'b0100, 2, "wd_m2");
        hold_check(300, 0, 10, 4'b0100, "wd_fc10");
        handover(4'b1000, 3, "wd_m3");
        hold_check(300, 0, WD, 4'b1000, "wd_fc_terminal");
`else
        handover(4'b0010, 1, "nowd_m1");
        hold_check(300, 0, 0, 4'b0010, "nowd_hold");
        handover(4'b1000, 3, "nowd_m3");
`endif

        // Async reset mid-tenure, away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        chk("async_grant", 32'(bus_grant), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_watchdog", 32'(watchdog), 32'h0);
        chk("async_owner", 32'(owner), 32'd3);
        bus_req = 4'hF;
        tick();
        tick();
        chk("held_reset_grant", 32'(bus_grant), 32'h0);
        rst = 1'b1;
        tick();
        chk("post_reset_grant", 32'(bus_grant), 32'h1);
        chk("post_reset_owner", 32'(owner), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
